// File: rtl/usb_sd_pkg.sv
// Shared types and constants for the USB-to-SD bulk transfer scheduler.
// Contents: scheduler state enum, handshake enum, default sizes, and the
// OUT-packet handshake decision helper.
package usb_sd_pkg;

    localparam int unsigned PKT_BYTES_DEF = 64;
    localparam int unsigned BLK_BYTES_DEF = 512;
    localparam int unsigned CNT_W_DEF     = 10;
    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned TO_CYC_DEF    = 4095;
    localparam int unsigned TMR_W         = 12;

    typedef enum logic [1:0] {
        IDLE,
        IN_TX,
        SD_WR,
        ERR
    } sched_state_t;

    typedef enum logic [1:0] {
        HS_NONE,
        HS_ACK,
        HS_NAK
    } hs_t;

    // Handshake for a completed OUT packet: bad CRC gets silence, full FIFO gets NAK.
    function automatic hs_t out_hs(input logic crc_ok, input logic fifo_full);
        hs_t hs;
        hs = HS_NONE;
        if (crc_ok) begin
            hs = fifo_full ? HS_NAK : HS_ACK;
        end
        return hs;
    endfunction

endpackage

// File: rtl/xfer_timer.sv
// Loadable down-counter watchdog.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : arm and load LOAD_VAL-1 (wins over clear)
//   clr_i        : disarm
//   expire_o     : high for the one cycle in which the armed count sits at 0,
//                  i.e. the LOAD_VAL-th cycle after the load edge
module xfer_timer #(
    parameter int unsigned W        = 12,
    parameter int unsigned LOAD_VAL = 4095
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         armed_q, armed_d;
    logic         expire_q, expire_d;

    // Next count; expiry disarms so the pulse is a single cycle.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load_i) begin
            cnt_d   = W'(LOAD_VAL - 1);
            armed_d = 1'b1;
        end else if (clr_i || expire_q) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (armed_q) begin
            cnt_d = cnt_q - W'(1);
        end
        expire_d = armed_d && (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/bulk_xfer_sched.sv
// Bulk transfer scheduler between USB bulk control, the read/write FIFOs and
// the SD controller. Answers IN/OUT with DATA/ACK/NAK, issues SD block reads
// and writes, and allows only one SD operation at a time.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   in_req_i, out_req_i          : host IN token / OUT packet received pulses
//   out_crc_ok_i                 : CRC status of the OUT packet
//   rd_count_i, wr_count_i       : FIFO occupancies in bytes
//   wr_full_i                    : write FIFO cannot take another packet
//   tx_done_i                    : DATA packet transmitted
//   sd_busy_i, sd_rd_done_i, sd_wr_done_i : SD controller status
//   clr_err_i                    : leave the error state
//   send_data_o/send_ack_o/send_nak_o     : handshake pulses
//   sd_rd_start_o/sd_wr_start_o  : SD block command pulses
//   blk_addr_o                   : current SD block address
//   xfer_err_o                   : error state indicator
module bulk_xfer_sched
    import usb_sd_pkg::*;
#(
    parameter int unsigned PKT_BYTES = PKT_BYTES_DEF,
    parameter int unsigned BLK_BYTES = BLK_BYTES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned TO_CYC    = TO_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_req_i,
    input  logic              out_req_i,
    input  logic              out_crc_ok_i,
    input  logic [CNT_W-1:0]  rd_count_i,
    input  logic [CNT_W-1:0]  wr_count_i,
    input  logic              wr_full_i,
    input  logic              tx_done_i,
    input  logic              sd_busy_i,
    input  logic              sd_rd_done_i,
    input  logic              sd_wr_done_i,
    input  logic              clr_err_i,
    output logic              send_data_o,
    output logic              send_ack_o,
    output logic              send_nak_o,
    output logic              sd_rd_start_o,
    output logic              sd_wr_start_o,
    output logic [ADDR_W-1:0] blk_addr_o,
    output logic              xfer_err_o
);

    sched_state_t      state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic              in_pend_q, in_pend_d;
    logic [ADDR_W-1:0] blk_addr_q, blk_addr_d;
    logic              send_data_q, send_data_d;
    logic              send_ack_q, send_ack_d;
    logic              send_nak_q, send_nak_d;
    logic              sd_rd_start_q, sd_rd_start_d;
    logic              sd_wr_start_q, sd_wr_start_d;
    logic              xfer_err_q, xfer_err_d;

    hs_t  hs;
    logic rd_done;
    logic timeout;
    logic sd_tmr_load, sd_tmr_clr, sd_tmr_exp;
    logic tx_tmr_load, tx_tmr_clr, tx_tmr_exp;
    logic rd_avail, wr_avail;

    assign rd_avail = (rd_count_i >= CNT_W'(PKT_BYTES));
    assign wr_avail = (wr_count_i >= CNT_W'(BLK_BYTES));

    // SD watchdog: reads and writes never overlap, so one timer covers both.
    xfer_timer #(
        .W        (TMR_W),
        .LOAD_VAL (TO_CYC)
    ) u_sd_tmr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (sd_tmr_load),
        .clr_i    (sd_tmr_clr),
        .expire_o (sd_tmr_exp)
    );

    // DATA transmit watchdog; separate because IN_TX can overlap a pending read.
    xfer_timer #(
        .W        (TMR_W),
        .LOAD_VAL (TO_CYC)
    ) u_tx_tmr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (tx_tmr_load),
        .clr_i    (tx_tmr_clr),
        .expire_o (tx_tmr_exp)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        rd_pend_d     = rd_pend_q;
        in_pend_d     = in_pend_q;
        blk_addr_d    = blk_addr_q;
        hs            = HS_NONE;
        send_data_d   = 1'b0;
        sd_rd_start_d = 1'b0;
        sd_wr_start_d = 1'b0;
        sd_tmr_clr    = 1'b0;
        tx_tmr_clr    = 1'b0;

        rd_done = rd_pend_q && sd_rd_done_i;
        // A done pulse arriving in the expiry cycle still counts as in time.
        timeout = (state_q != ERR) &&
                  ((rd_pend_q && sd_tmr_exp && !sd_rd_done_i) ||
                   (state_q == SD_WR && sd_tmr_exp && !sd_wr_done_i) ||
                   (state_q == IN_TX && tx_tmr_exp && !tx_done_i));

        // Read completion is tracked in every state, including ERR.
        if (rd_done) begin
            rd_pend_d  = 1'b0;
            blk_addr_d = blk_addr_q + ADDR_W'(1);
            sd_tmr_clr = 1'b1;
        end

        if (state_q == ERR || timeout) begin
            // Error handling also covers the cycle in which a timeout fires.
            if (in_req_i || out_req_i) begin
                hs = HS_NAK;
            end
            state_d = ERR;
            if (state_q == ERR && clr_err_i) begin
                state_d    = IDLE;
                rd_pend_d  = 1'b0;
                in_pend_d  = 1'b0;
                sd_tmr_clr = 1'b1;
                tx_tmr_clr = 1'b1;
            end
        end else begin
            if (out_req_i) begin
                hs = out_hs(out_crc_ok_i, wr_full_i);
            end
            case (state_q)
                IDLE: begin
                    if (out_req_i) begin
                        if (in_req_i) begin
                            in_pend_d = 1'b1;
                        end
                    end else if (in_req_i || in_pend_q) begin
                        in_pend_d = 1'b0;
                        if (rd_avail) begin
                            send_data_d = 1'b1;
                            state_d     = IN_TX;
                        end else begin
                            hs = HS_NAK;
                            if (!rd_pend_q && !sd_busy_i) begin
                                sd_rd_start_d = 1'b1;
                                rd_pend_d     = 1'b1;
                            end
                        end
                    end else if (wr_avail && !rd_pend_q && !sd_busy_i) begin
                        sd_wr_start_d = 1'b1;
                        state_d       = SD_WR;
                    end
                end
                IN_TX: begin
                    if (in_req_i) begin
                        in_pend_d = 1'b1;
                    end
                    if (tx_done_i) begin
                        state_d    = IDLE;
                        tx_tmr_clr = 1'b1;
                    end
                end
                SD_WR: begin
                    if (in_req_i) begin
                        in_pend_d = 1'b1;
                    end
                    if (sd_wr_done_i) begin
                        blk_addr_d = blk_addr_q + ADDR_W'(1);
                        state_d    = IDLE;
                        sd_tmr_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        send_ack_d  = (hs == HS_ACK);
        send_nak_d  = (hs == HS_NAK);
        xfer_err_d  = (state_d == ERR);
        sd_tmr_load = sd_rd_start_d || sd_wr_start_d;
        tx_tmr_load = send_data_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rd_pend_q     <= 1'b0;
            in_pend_q     <= 1'b0;
            blk_addr_q    <= '0;
            send_data_q   <= 1'b0;
            send_ack_q    <= 1'b0;
            send_nak_q    <= 1'b0;
            sd_rd_start_q <= 1'b0;
            sd_wr_start_q <= 1'b0;
            xfer_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_pend_q     <= rd_pend_d;
            in_pend_q     <= in_pend_d;
            blk_addr_q    <= blk_addr_d;
            send_data_q   <= send_data_d;
            send_ack_q    <= send_ack_d;
            send_nak_q    <= send_nak_d;
            sd_rd_start_q <= sd_rd_start_d;
            sd_wr_start_q <= sd_wr_start_d;
            xfer_err_q    <= xfer_err_d;
        end
    end

    assign send_data_o   = send_data_q;
    assign send_ack_o    = send_ack_q;
    assign send_nak_o    = send_nak_q;
    assign sd_rd_start_o = sd_rd_start_q;
    assign sd_wr_start_o = sd_wr_start_q;
    assign blk_addr_o    = blk_addr_q;
    assign xfer_err_o    = xfer_err_q;

endmodule

// File: tb/tb_bulk_xfer_sched.sv
// Self-checking bench for bulk_xfer_sched: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level reference model.
module tb_bulk_xfer_sched;

    localparam int unsigned TO = 4095;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_req = 0, out_req = 0, out_crc_ok = 0, wr_full = 0;
    logic [9:0]  rd_count = '0, wr_count = '0;
    logic        tx_done = 0, sd_busy = 0, sd_rd_done = 0, sd_wr_done = 0, clr_err = 0;
    logic        send_data, send_ack, send_nak, sd_rd_start, sd_wr_start, xfer_err;
    logic [31:0] blk_addr;

    int n_chk  = 0;
    int n_fail = 0;

    bulk_xfer_sched dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_req_i      (in_req),
        .out_req_i     (out_req),
        .out_crc_ok_i  (out_crc_ok),
        .rd_count_i    (rd_count),
        .wr_count_i    (wr_count),
        .wr_full_i     (wr_full),
        .tx_done_i     (tx_done),
        .sd_busy_i     (sd_busy),
        .sd_rd_done_i  (sd_rd_done),
        .sd_wr_done_i  (sd_wr_done),
        .clr_err_i     (clr_err),
        .send_data_o   (send_data),
        .send_ack_o    (send_ack),
        .send_nak_o    (send_nak),
        .sd_rd_start_o (sd_rd_start),
        .sd_wr_start_o (sd_wr_start),
        .blk_addr_o    (blk_addr),
        .xfer_err_o    (xfer_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 sending DATA, 2 writing a block, 3 error
    int          m_mode;
    bit          m_rd_out;      // an SD read is outstanding
    bit          m_in_wait;     // one buffered IN token
    logic [31:0] m_addr;
    longint      cyc = 0;
    longint      sd_deadline, tx_deadline;
    bit          m_valid = 0;
    // expected {data, ack, nak, rd_start, wr_start, err}
    logic [5:0]  exp_vec;
    logic [31:0] exp_addr;

    always @(posedge clk) begin
        bit d, a, n, rs, ws, rd_out0, expired;
        int nxt;
        cyc++;
        d = 0; a = 0; n = 0; rs = 0; ws = 0;
        if (rst) begin
            m_mode = 0; m_rd_out = 0; m_in_wait = 0; m_addr = 0;
            nxt = 0;
        end else begin
            nxt     = m_mode;
            rd_out0 = m_rd_out;
            expired = (m_mode != 3) &&
                      ((rd_out0 && cyc == sd_deadline && !sd_rd_done) ||
                       (m_mode == 2 && cyc == sd_deadline && !sd_wr_done) ||
                       (m_mode == 1 && cyc == tx_deadline && !tx_done));
            if (rd_out0 && sd_rd_done) begin
                m_rd_out = 0;
                m_addr   = m_addr + 1;
            end
            if (m_mode == 3 || expired) begin
                n   = in_req || out_req;
                nxt = 3;
                if (m_mode == 3 && clr_err) begin
                    nxt = 0; m_rd_out = 0; m_in_wait = 0;
                end
            end else begin
                if (out_req && out_crc_ok) begin
                    if (wr_full) n = 1; else a = 1;
                end
                if (m_mode == 0) begin
                    if (out_req) begin
                        if (in_req) m_in_wait = 1;
                    end else if (in_req || m_in_wait) begin
                        m_in_wait = 0;
                        if (rd_count >= 64) begin
                            d = 1; nxt = 1; tx_deadline = cyc + TO;
                        end else begin
                            n = 1;
                            if (!rd_out0 && !sd_busy) begin
                                rs = 1; m_rd_out = 1; sd_deadline = cyc + TO;
                            end
                        end
                    end else if (wr_count >= 512 && !rd_out0 && !sd_busy) begin
                        ws = 1; nxt = 2; sd_deadline = cyc + TO;
                    end
                end else if (m_mode == 1) begin
                    if (in_req) m_in_wait = 1;
                    if (tx_done) nxt = 0;
                end else begin
                    if (in_req) m_in_wait = 1;
                    if (sd_wr_done) begin
                        m_addr = m_addr + 1; nxt = 0;
                    end
                end
            end
        end
        m_mode   = nxt;
        exp_vec  = {d, a, n, rs, ws, (nxt == 3)};
        exp_addr = m_addr;
        m_valid  = 1;
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            n_chk++;
            if ({send_data, send_ack, send_nak, sd_rd_start, sd_wr_start, xfer_err} !== exp_vec) begin
                n_fail++;
                $display("FAIL model_outputs t=%0t got %b expected %b (data,ack,nak,rd,wr,err)",
                         $time, {send_data, send_ack, send_nak, sd_rd_start, sd_wr_start, xfer_err}, exp_vec);
            end
            n_chk++;
            if (blk_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL model_blk_addr t=%0t got %0d expected %0d", $time, blk_addr, exp_addr);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [5:0] exp);
        chk(nm, 32'({send_data, send_ack, send_nak, sd_rd_start, sd_wr_start, xfer_err}), 32'(exp));
    endtask

    initial begin
        // reset
        rst = 1'b1;
        tick(); tick();
        chk_outs("reset_outputs", 6'b000000);
        chk("reset_blk_addr", blk_addr, 0);
        rst = 1'b0;
        tick();

        // IN with empty read FIFO: NAK plus block read
        rd_count = 0; in_req = 1; tick(); in_req = 0;
        chk_outs("in_empty_nak_rdstart", 6'b001100);
        chk("in_empty_addr", blk_addr, 0);
        tick();
        sd_rd_done = 1; tick(); sd_rd_done = 0;
        chk("rd_done_addr", blk_addr, 1);

        // IN with data, two more INs during IN_TX: only one is buffered
        rd_count = 64; in_req = 1; tick(); in_req = 0;
        chk_outs("in_data", 6'b100000);
        in_req = 1; tick(); in_req = 0;
        chk_outs("in_during_tx_silent", 6'b000000);
        in_req = 1; tick(); in_req = 0;
        tx_done = 1; tick(); tx_done = 0;
        tick();
        chk_outs("in_pend_served", 6'b100000);
        tx_done = 1; tick(); tx_done = 0;
        tick();
        chk_outs("second_in_dropped", 6'b000000);

        // OUT handshakes
        out_crc_ok = 1; wr_full = 0; out_req = 1; tick(); out_req = 0;
        chk_outs("out_ack", 6'b010000);
        wr_full = 1; out_req = 1; tick(); out_req = 0;
        chk_outs("out_full_nak", 6'b001000);
        out_crc_ok = 0; wr_full = 0; out_req = 1; tick(); out_req = 0;
        chk_outs("out_badcrc_silent", 6'b000000);

        // write held off by an outstanding read
        rd_count = 0; in_req = 1; tick(); in_req = 0;
        chk_outs("rd2_start", 6'b001100);
        wr_count = 512;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_blocked_by_rd", 32'(sd_wr_start), 0);
        end
        sd_rd_done = 1; tick(); sd_rd_done = 0;
        chk("rd2_addr", blk_addr, 2);
        chk("wr_not_same_cycle", 32'(sd_wr_start), 0);
        tick();
        chk_outs("wr_start_after_rd", 6'b000010);
        wr_count = 0;
        sd_wr_done = 1; tick(); sd_wr_done = 0;
        chk("wr_done_addr", blk_addr, 3);

        // simultaneous IN and OUT: ACK first, DATA next cycle
        rd_count = 64; out_crc_ok = 1; in_req = 1; out_req = 1; tick();
        in_req = 0; out_req = 0;
        chk_outs("same_cycle_ack", 6'b010000);
        tick();
        chk_outs("same_cycle_data", 6'b100000);
        tx_done = 1; tick(); tx_done = 0;
        tick();

        // SD_WR timeout boundary
        wr_count = 512; tick(); wr_count = 0;
        chk_outs("to_wr_start", 6'b000010);
        repeat (TO - 1) tick();
        chk("to_not_yet", 32'(xfer_err), 0);
        tick();
        chk("to_err", 32'(xfer_err), 1);
        in_req = 1; tick(); in_req = 0;
        chk_outs("err_in_nak", 6'b001001);
        out_req = 1; out_crc_ok = 1; tick(); out_req = 0;
        chk_outs("err_out_nak", 6'b001001);
        clr_err = 1; tick(); clr_err = 0;
        chk("clr_err", 32'(xfer_err), 0);
        chk("err_keeps_addr", blk_addr, 3);

        // reset in the middle of a block write
        wr_count = 512; tick(); wr_count = 0;
        chk_outs("rst_wr_start", 6'b000010);
        tick(); tick();
        rst = 1; tick(); rst = 0;
        chk_outs("mid_rst_outputs", 6'b000000);
        chk("mid_rst_addr", blk_addr, 0);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            rst        = ($urandom_range(0, 599) == 0);
            in_req     = ($urandom_range(0, 5) == 0);
            out_req    = ($urandom_range(0, 7) == 0);
            out_crc_ok = ($urandom_range(0, 3) != 0);
            wr_full    = ($urandom_range(0, 3) == 0);
            sd_busy    = ($urandom_range(0, 4) == 0);
            tx_done    = ($urandom_range(0, 5) == 0);
            sd_rd_done = ($urandom_range(0, 7) == 0);
            sd_wr_done = ($urandom_range(0, 7) == 0);
            clr_err    = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 3);
            rd_count = (r == 0) ? 10'd0 : (r == 1) ? 10'd63 : (r == 2) ? 10'd64 : 10'd300;
            r = $urandom_range(0, 3);
            wr_count = (r == 0) ? 10'd0 : (r == 1) ? 10'd511 : (r == 2) ? 10'd512 : 10'd900;
            tick();
        end
        rst = 0; in_req = 0; out_req = 0; tx_done = 0; sd_rd_done = 0; sd_wr_done = 0; clr_err = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
